// File: rtl/daq_pkg.sv
// Shared DAQ constants and the per-bit debounce state encoding.
package daq_pkg;

  localparam int unsigned DAQ_CLK_HZ             = 50_000_000;
  localparam int unsigned DAQ_SW_DEBOUNCE_CYCLES = 500_000;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_SETTLING = 1'b1
  } db_state_e;

endpackage

// File: rtl/sw_debouncer_if.sv
// Switch conditioning bus: raw pins in, debounced level and change strobes out.
interface sw_debouncer_if #(
  parameter int unsigned WIDTH = 4
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_debounced;
  logic [WIDTH-1:0] sw_changed;
  logic             sw_any_change;

  modport master (
    output sw_raw,
    input  sw_debounced,
    input  sw_changed,
    input  sw_any_change
  );

  modport slave (
    input  sw_raw,
    output sw_debounced,
    output sw_changed,
    output sw_any_change
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser chain, settle counter and STABLE/SETTLING FSM.
module sw_debounce_bit
  import daq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = DAQ_SW_DEBOUNCE_CYCLES,
  parameter logic        RESET_VALUE   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_changed,
  output logic o_fire
);

  localparam int unsigned    CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  db_state_e              r_state;
  logic                   r_level;
  logic                   r_changed;
  logic                   w_s;
  logic                   w_fire;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Same-cycle view of the acceptance decision, so the top can register the
  // any-change flag alongside the per-bit strobe.
  assign w_fire = (r_state == DB_SETTLING) && (w_s != r_level) && (r_cnt == CNT_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= DB_STABLE;
      r_cnt     <= '0;
      r_level   <= RESET_VALUE;
      r_changed <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      case (r_state)
        DB_STABLE: begin
          if (w_s != r_level) begin
            r_state <= DB_SETTLING;
            r_cnt   <= CW'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        DB_SETTLING: begin
          if (w_s == r_level) begin
            r_state <= DB_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state   <= DB_STABLE;
            r_cnt     <= '0;
            r_level   <= w_s;
            r_changed <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= DB_STABLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_changed = r_changed;
  assign o_fire    = w_fire;

endmodule

// File: rtl/sw_debouncer.sv
// Slide-switch conditioner for the HPS switch PIO: per-bit sync + debounce,
// clean level, per-bit change strobe and a registered any-change flag.
module sw_debouncer
  import daq_pkg::*;
#(
  parameter int unsigned      WIDTH         = 4,
  parameter int unsigned      SYNC_STAGES   = 2,
  parameter int unsigned      STABLE_CYCLES = DAQ_SW_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic           clk_clk,
  input  logic           reset_reset_n,
  sw_debouncer_if.slave  sw_io
);

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_changed;
  logic [WIDTH-1:0] w_fire;
  logic             r_any_change;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_VALUE   (RESET_VALUE[gi])
    ) u_bit (
      .i_clk     (clk_clk),
      .i_rst_n   (reset_reset_n),
      .i_raw     (sw_io.sw_raw[gi]),
      .o_level   (w_level[gi]),
      .o_changed (w_changed[gi]),
      .o_fire    (w_fire[gi])
    );
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_any_change <= 1'b0;
    end else begin
      r_any_change <= |w_fire;
    end
  end

  assign sw_io.sw_debounced  = w_level;
  assign sw_io.sw_changed    = w_changed;
  assign sw_io.sw_any_change = r_any_change;

endmodule
